// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences a dot product through an external MULADD unit.
// Streams operand pairs into the MAC, drains its pipeline, and captures the
// result. A 20-bit shadow accumulator cross-checks the MAC output.
module mac_dot_seq #(
  parameter int MAC_LAT = 1,
  parameter int LEN_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_clr,
  input  logic [19:0]      mac_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [19:0]      res_data,
  output logic             res_err
);

  // CLEAR is the only state with bit 2 set, so mac_clr comes straight off a flop.
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_CLEAR = 3'b100;
  localparam logic [2:0] S_FEED  = 3'b001;
  localparam logic [2:0] S_DRAIN = 3'b010;
  localparam logic [2:0] S_DONE  = 3'b011;

  logic [2:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [2:0]       dcnt;
  logic [19:0]      shadow;
  logic             xfer;

  assign xfer      = in_valid && (state == S_FEED);
  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_FEED);
  assign res_valid = (state == S_DONE);
  assign mac_clr   = state[2];

  // Operand register: a transfer loads the pair, every other cycle feeds zeros
  // so stalls, CLEAR and DRAIN leave the MAC accumulator untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mac_a <= '0;
      mac_b <= '0;
    end else begin
      mac_a <= xfer ? in_a : 8'd0;
      mac_b <= xfer ? in_b : 8'd0;
    end
  end

  // Control FSM, element/drain counters, shadow accumulator and result capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dcnt     <= '0;
      shadow   <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= len;
            if (len == '0) begin
              state    <= S_DONE;
              res_data <= '0;
              res_err  <= 1'b0;
            end else begin
              state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          shadow <= '0;
          state  <= S_FEED;
        end
        S_FEED: begin
          if (xfer) begin
            cnt    <= cnt - 1'b1;
            shadow <= shadow + ({12'd0, in_a} * {12'd0, in_b});
            if (cnt == LEN_W'(1)) begin
              state <= S_DRAIN;
              dcnt  <= 3'(MAC_LAT);
            end
          end
        end
        S_DRAIN: begin
          // Last operand is in mac_q once MAC_LAT+1 edges have passed.
          if (dcnt == 3'd0) begin
            state    <= S_DONE;
            res_data <= mac_q;
            res_err  <= (mac_q != shadow);
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with an accumulating MAC_LAT=1 MULADD model.
module tb_mac_dot_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic [7:0]  mac_a, mac_b;
  logic        mac_clr;
  logic [19:0] mac_q;
  logic        res_valid;
  logic        res_ready;
  logic [19:0] res_data;
  logic        res_err;

  logic [19:0] acc;
  logic        force_err;
  int          clr_cnt, rdy_cnt;
  int          vectors, errs;
  logic [7:0]  va [0:31];
  logic [7:0]  vb [0:31];

  mac_dot_seq #(.MAC_LAT(1), .LEN_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_q(mac_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 CLK = ~CLK;

  // MULADD model: clr zeroes, otherwise accumulate A*B one edge after it appears.
  always @(posedge CLK or posedge RST) begin
    if (RST)          acc <= '0;
    else if (mac_clr) acc <= '0;
    else              acc <= acc + ({12'd0, mac_a} * {12'd0, mac_b});
  end
  assign mac_q = acc + {19'd0, force_err};

  // Event counters for mac_clr pulses and in_ready cycles.
  always @(posedge CLK) begin
    if (mac_clr)  clr_cnt <= clr_cnt + 1;
    if (in_ready) rdy_cnt <= rdy_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from IDLE through to DONE, checking along the way.
  task automatic run_op(input string tag, input int n, input int gap,
                        input logic [19:0] exp_d, input logic exp_e);
    int c0;
    c0 = clr_cnt;
    start = 1'b1; len = 8'(n);
    @(negedge CLK);
    start = 1'b0;
    chk({tag, ".clr"}, 32'(mac_clr), 1);
    chk({tag, ".clr_ops"}, {mac_a, mac_b}, 0);
    chk({tag, ".clr_rdy"}, 32'(in_ready), 0);
    @(negedge CLK);
    chk({tag, ".feed_rdy"}, 32'(in_ready), 1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      @(negedge CLK);
      in_valid = 1'b0; in_a = 8'hA5; in_b = 8'h5A;
      chk({tag, ".ops"}, {mac_a, mac_b}, {va[i], vb[i]});
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge CLK);
          chk({tag, ".gap_ops"}, {mac_a, mac_b}, 0);
          chk({tag, ".gap_busy"}, 32'(busy), 1);
        end
      end
    end
    chk({tag, ".drain_rdy"}, 32'(in_ready), 0);
    chk({tag, ".drain_v0"}, 32'(res_valid), 0);
    @(negedge CLK);
    chk({tag, ".drain_v1"}, 32'(res_valid), 0);
    chk({tag, ".drain_ops"}, {mac_a, mac_b}, 0);
    @(negedge CLK);
    chk({tag, ".valid"}, 32'(res_valid), 1);
    chk({tag, ".data"}, 32'(res_data), 32'(exp_d));
    chk({tag, ".err"}, 32'(res_err), 32'(exp_e));
    chk({tag, ".clr_pulses"}, 32'(clr_cnt), 32'(c0 + 1));
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    chk({tag, ".idle"}, 32'(busy), 0);
  endtask

  initial begin
    int c0, r0;
    vectors = 0; errs = 0; clr_cnt = 0; rdy_cnt = 0;
    RST = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
    res_ready = 1'b0; force_err = 1'b0;

    // Reset state
    @(negedge CLK); @(negedge CLK);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.rdy", 32'(in_ready), 0);
    chk("rst.ops", {mac_a, mac_b}, 0);
    chk("rst.clr", 32'(mac_clr), 0);
    chk("rst.valid", 32'(res_valid), 0);
    chk("rst.data", 32'(res_data), 0);
    chk("rst.err", 32'(res_err), 0);
    RST = 1'b0;
    @(negedge CLK);

    // Three elements back to back: 2*3 + 4*5 + 255*255 = 65051
    va[0] = 8'd2;   vb[0] = 8'd3;
    va[1] = 8'd4;   vb[1] = 8'd5;
    va[2] = 8'd255; vb[2] = 8'd255;
    run_op("A", 3, 0, 20'd65051, 1'b0);
    handshake("A");

    // Same stream with 3-cycle stalls between elements
    run_op("B", 3, 3, 20'd65051, 1'b0);
    handshake("B");

    // len=0: immediate zero result, no clear, never ready
    c0 = clr_cnt; r0 = rdy_cnt;
    start = 1'b1; len = 8'd0;
    @(negedge CLK);
    start = 1'b0;
    chk("Z.valid", 32'(res_valid), 1);
    chk("Z.data", 32'(res_data), 0);
    chk("Z.err", 32'(res_err), 0);
    handshake("Z");
    chk("Z.no_clr", 32'(clr_cnt), 32'(c0));
    chk("Z.no_rdy", 32'(rdy_cnt), 32'(r0));

    // Result held while res_ready is low; start in DONE is ignored
    va[0] = 8'd3; vb[0] = 8'd4;
    run_op("H", 1, 0, 20'd12, 1'b0);
    c0 = clr_cnt;
    for (int k = 0; k < 5; k++) begin
      start = (k == 2); len = 8'd5;
      @(negedge CLK);
      start = 1'b0;
      chk("H.hold_valid", 32'(res_valid), 1);
      chk("H.hold_data", 32'(res_data), 12);
    end
    chk("H.start_ignored", 32'(clr_cnt), 32'(c0));
    handshake("H");

    // Start in the first IDLE cycle; 17 * 65025 wraps mod 2^20 to 56849
    for (int i = 0; i < 17; i++) begin va[i] = 8'd255; vb[i] = 8'd255; end
    run_op("W", 17, 0, 20'd56849, 1'b0);
    handshake("W");

    // Reset mid-FEED after one element
    start = 1'b1; len = 8'd3;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("R.ops", {mac_a, mac_b}, 16'h0101);
    RST = 1'b1;
    #1;
    chk("R.busy", 32'(busy), 0);
    chk("R.rdy", 32'(in_ready), 0);
    chk("R.ops0", {mac_a, mac_b}, 0);
    chk("R.valid", 32'(res_valid), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("R.idle", 32'(busy), 0);
    va[0] = 8'd7; vb[0] = 8'd9;
    run_op("E", 1, 0, 20'd63, 1'b0);
    handshake("E");

    // MAC model off by one: captured value 64, error flagged
    force_err = 1'b1;
    run_op("F", 1, 0, 20'd64, 1'b1);
    handshake("F");
    force_err = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
